// File: rtl/regfile_scoreboard.sv
// Register file (1 write, 2 async read ports) with a per-register pending-write scoreboard.
// Optional write-through forwarding on both read ports when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Ld,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] select_reg_A,
  input  logic [ADDR_W-1:0] select_reg_B,
  output logic [DATA_W-1:0] data_out_A,
  output logic [DATA_W-1:0] data_out_B,
  output logic              busy_A,
  output logic              busy_B,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_conflict,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [ADDR_W:0]     busy_count_r;
  logic [ADDR_W:0]     busy_count_nxt_s;
  logic                wr_ok_s;
  logic                acc_s;
  logic                dec_s;

  // Address maps onto the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 32'sd1) && (a == {ADDR_W{1'b0}});
  endfunction

  // Issue acceptance and scoreboard counter steering.
  always_comb begin
    wr_ok_s = Ld && !is_zero(write_reg);
    acc_s   = issue_en && !is_zero(issue_reg) &&
              (!busy_r[issue_reg] || (Ld && (write_reg == issue_reg)));
    dec_s   = wr_ok_s && busy_r[write_reg];
    issue_conflict = issue_en && !is_zero(issue_reg) && !acc_s;
    case ({acc_s, dec_s})
      2'b10:   busy_count_nxt_s = busy_count_r + CNT_ONE;
      2'b01:   busy_count_nxt_s = busy_count_r - CNT_ONE;
      default: busy_count_nxt_s = busy_count_r;
    endcase
  end

  // Register storage, busy bits and outstanding-write counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      busy_r       <= {NUM_REGS{1'b0}};
      busy_count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        regs_r[write_reg] <= data;
        busy_r[write_reg] <= 1'b0;
      end
      // Issue is applied last so it wins over a same-cycle writeback clear.
      if (acc_s) begin
        busy_r[issue_reg] <= 1'b1;
      end
      busy_count_r <= busy_count_nxt_s;
    end
  end

  assign busy_count = busy_count_r;

  // Read port A.
  always_comb begin
    data_out_A = {DATA_W{1'b0}};
    busy_A     = 1'b0;
    if (is_zero(select_reg_A)) begin
      data_out_A = {DATA_W{1'b0}};
      busy_A     = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_ok_s && (write_reg == select_reg_A)) begin
      data_out_A = data;
      busy_A     = 1'b0;
`endif
    end else begin
      data_out_A = regs_r[select_reg_A];
      busy_A     = busy_r[select_reg_A];
    end
  end

  // Read port B.
  always_comb begin
    data_out_B = {DATA_W{1'b0}};
    busy_B     = 1'b0;
    if (is_zero(select_reg_B)) begin
      data_out_B = {DATA_W{1'b0}};
      busy_B     = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_ok_s && (write_reg == select_reg_B)) begin
      data_out_B = data;
      busy_B     = 1'b0;
`endif
    end else begin
      data_out_B = regs_r[select_reg_B];
      busy_B     = busy_r[select_reg_B];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Ld;
  logic [4:0]  write_reg;
  logic [31:0] data;
  logic [4:0]  select_reg_A;
  logic [4:0]  select_reg_B;
  logic [31:0] data_out_A;
  logic [31:0] data_out_B;
  logic        busy_A;
  logic        busy_B;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic        issue_conflict;
  logic [5:0]  busy_count;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .Clk(Clk), .Rst(Rst), .Ld(Ld), .write_reg(write_reg), .data(data),
    .select_reg_A(select_reg_A), .select_reg_B(select_reg_B),
    .data_out_A(data_out_A), .data_out_B(data_out_B),
    .busy_A(busy_A), .busy_B(busy_B),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .issue_conflict(issue_conflict), .busy_count(busy_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Rst = 1'b0; Ld = 1'b0; issue_en = 1'b0;
  endtask

  task automatic test_reset();
    Ld = 1'b1; write_reg = 5'd4; data = 32'h1234_5678;
    issue_en = 1'b1; issue_reg = 5'd2;
    tick();
    idle();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      select_reg_A = i[4:0];
      select_reg_B = i[4:0];
      #1;
      checks++;
      if (data_out_A !== 32'h0 || data_out_B !== 32'h0) begin
        errors++;
        $display("FAIL reset_data addr=%0d A=%h B=%h expected 0", i, data_out_A, data_out_B);
      end
      checks++;
      if (busy_A !== 1'b0 || busy_B !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy addr=%0d A=%b B=%b expected 0", i, busy_A, busy_B);
      end
    end
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_count got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_write();
    Ld = 1'b1; write_reg = 5'd5; data = 32'hDEAD_BEEF;
    tick();
    Ld = 1'b0; select_reg_A = 5'd5; select_reg_B = 5'd5;
    #1;
    checks++;
    if (data_out_A !== 32'hDEAD_BEEF || data_out_B !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read A=%h B=%h expected deadbeef", data_out_A, data_out_B);
    end
    Ld = 1'b1; write_reg = 5'd0; data = 32'hFFFF_FFFF;
    tick();
    Ld = 1'b0; select_reg_A = 5'd0;
    #1;
    checks++;
    if (data_out_A !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg got %h expected 0", data_out_A);
    end
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL write_count got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_issue();
    issue_en = 1'b1; issue_reg = 5'd7;
    #1;
    checks++;
    if (issue_conflict !== 1'b0) begin
      errors++;
      $display("FAIL issue_first_conflict got %b expected 0", issue_conflict);
    end
    tick();
    issue_en = 1'b0; select_reg_A = 5'd7;
    #1;
    checks++;
    if (busy_A !== 1'b1 || busy_count !== 6'd1) begin
      errors++;
      $display("FAIL issue_busy busy_A=%b count=%0d expected 1/1", busy_A, busy_count);
    end
    issue_en = 1'b1; issue_reg = 5'd7;
    #1;
    checks++;
    if (issue_conflict !== 1'b1) begin
      errors++;
      $display("FAIL issue_conflict got %b expected 1", issue_conflict);
    end
    tick();
    issue_en = 1'b1; issue_reg = 5'd0;
    #1;
    checks++;
    if (issue_conflict !== 1'b0 || busy_count !== 6'd1) begin
      errors++;
      $display("FAIL issue_conflict_hold conflict=%b count=%0d expected 0/1", issue_conflict, busy_count);
    end
    tick();
    issue_en = 1'b0;
    Ld = 1'b1; write_reg = 5'd9; data = 32'h0000_0099;
    tick();
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL nonbusy_write_count got %0d expected 1", busy_count);
    end
    Ld = 1'b1; write_reg = 5'd7; data = 32'd9;
    tick();
    Ld = 1'b0;
    #1;
    checks++;
    if (busy_A !== 1'b0 || busy_count !== 6'd0 || data_out_A !== 32'd9) begin
      errors++;
      $display("FAIL writeback busy_A=%b count=%0d data=%h expected 0/0/9", busy_A, busy_count, data_out_A);
    end
  endtask

  task automatic test_same_cycle();
    issue_en = 1'b1; issue_reg = 5'd3;
    tick();
    Ld = 1'b1; write_reg = 5'd3; data = 32'h0000_0033;
    #1;
    checks++;
    if (issue_conflict !== 1'b0) begin
      errors++;
      $display("FAIL same_conflict got %b expected 0", issue_conflict);
    end
    tick();
    idle(); select_reg_A = 5'd3;
    #1;
    checks++;
    if (busy_A !== 1'b1 || busy_count !== 6'd1 || data_out_A !== 32'h0000_0033) begin
      errors++;
      $display("FAIL same_cycle busy_A=%b count=%0d data=%h expected 1/1/33", busy_A, busy_count, data_out_A);
    end
    Ld = 1'b1; write_reg = 5'd3; data = 32'h0000_0034;
    tick();
    Ld = 1'b0;
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL same_release got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_bypass();
    Ld = 1'b1; write_reg = 5'd12; data = 32'h0000_0011;
    issue_en = 1'b1; issue_reg = 5'd12;
    tick();
    issue_en = 1'b0;
    Ld = 1'b1; write_reg = 5'd12; data = 32'h0000_00AB; select_reg_B = 5'd12;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (data_out_B !== 32'h0000_00AB || busy_B !== 1'b0) begin
      errors++;
      $display("FAIL bypass_same data=%h busy=%b expected ab/0", data_out_B, busy_B);
    end
`else
    checks++;
    if (data_out_B !== 32'h0000_0011 || busy_B !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_same data=%h busy=%b expected 11/1", data_out_B, busy_B);
    end
`endif
    tick();
    Ld = 1'b0;
    #1;
    checks++;
    if (data_out_B !== 32'h0000_00AB || busy_B !== 1'b0 || busy_count !== 6'd0) begin
      errors++;
      $display("FAIL bypass_next data=%h busy=%b count=%0d expected ab/0/0", data_out_B, busy_B, busy_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      issue_en = 1'b1; issue_reg = i[4:0];
      #1;
      checks++;
      if (issue_conflict !== 1'b0) begin
        errors++;
        $display("FAIL fill_conflict reg=%0d got %b expected 0", i, issue_conflict);
      end
      tick();
    end
    issue_en = 1'b1; issue_reg = 5'd5;
    #1;
    checks++;
    if (busy_count !== 6'd31 || issue_conflict !== 1'b1) begin
      errors++;
      $display("FAIL fill_full count=%0d conflict=%b expected 31/1", busy_count, issue_conflict);
    end
    tick();
    checks++;
    if (busy_count !== 6'd31) begin
      errors++;
      $display("FAIL fill_nowrap got %0d expected 31", busy_count);
    end
    idle();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      issue_en = 1'b1; issue_reg = i[4:0];
      tick();
    end
    issue_en = 1'b0;
    checks++;
    if (busy_count !== 6'd10) begin
      errors++;
      $display("FAIL partial_count got %0d expected 10", busy_count);
    end
    Rst = 1'b1; issue_en = 1'b1; issue_reg = 5'd11;
    Ld = 1'b1; write_reg = 5'd20; data = 32'h0000_0055;
    tick();
    idle(); select_reg_A = 5'd1; select_reg_B = 5'd20;
    #1;
    checks++;
    if (busy_count !== 6'd0 || busy_A !== 1'b0 || data_out_B !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset count=%0d busy_A=%b dataB=%h expected 0/0/0", busy_count, busy_A, data_out_B);
    end
  endtask

  initial begin
    Rst = 1'b1; Ld = 1'b0; write_reg = 5'd0; data = 32'h0;
    select_reg_A = 5'd0; select_reg_B = 5'd0; issue_en = 1'b0; issue_reg = 5'd0;
    tick();
    tick();
    Rst = 1'b0;
    test_reset();
    test_write();
    test_issue();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
